// File: rtl/rf_pkg.sv
// Shared opcodes, FSM encodings and default widths for the register file arbiter.
package rf_pkg;
    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 3;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_ADD   = 2'b10;
    localparam logic [1:0] OP_NOP   = 2'b11;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_RMW_WB = 1'b1
    } rf_state_t;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; rr_last remembers the most recent winner.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [1:0] req,
    output logic [1:0] grant
);
    logic rr_last;

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = rr_last ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    // Reset to 1 so client 0 holds first priority.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    rr_last <= 1'b1;
        else if (|grant) rr_last <= grant[1];
    end
endmodule

// File: rtl/rf_arbiter.sv
// Two-client read/write/add front end for an 8-entry register file; adds stall one cycle for write-back.
module rf_arbiter
    import rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0,
    input  logic [1:0]        op0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] data0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic [1:0]        op1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] data1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] rf_wAddr,
    output logic [DATA_W-1:0] rf_wData,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_rAddr,
    input  logic [DATA_W-1:0] rf_rData
);
    rf_state_t                 state, state_nxt;
    logic [1:0]                grant;
    logic [1:0]                win_op;
    logic [ADDR_W-1:0]         win_addr;
    logic [DATA_W-1:0]         win_data;
    logic                      win_rd;
    logic [ADDR_W-1:0]         wb_addr;
    logic [DATA_W-1:0]         wb_data;
    logic [1:0]                rvalid_q;
    logic [1:0][DATA_W-1:0]    rdata_q;

    rr_arbiter2 u_rr (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (state == ST_IDLE),
        .req     ({req1, req0}),
        .grant   (grant)
    );

    assign win_op   = grant[1] ? op1   : op0;
    assign win_addr = grant[1] ? addr1 : addr0;
    assign win_data = grant[1] ? data1 : data0;
    assign win_rd   = (|grant) && (win_op == OP_READ || win_op == OP_ADD);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if ((|grant) && win_op == OP_ADD) state_nxt = ST_RMW_WB;
            ST_RMW_WB: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Grants and write enable are gated by reset so a mid-RMW reset drops the write at once.
    always_comb begin
        gnt0     = grant[0] & reset_n;
        gnt1     = grant[1] & reset_n;
        rf_we    = 1'b0;
        rf_wAddr = win_addr;
        rf_wData = win_data;
        rf_rAddr = win_addr;
        if (state == ST_RMW_WB) begin
            rf_we    = reset_n;
            rf_wAddr = wb_addr;
            rf_wData = wb_data;
            rf_rAddr = wb_addr;
        end else if ((|grant) && win_op == OP_WRITE) begin
            rf_we = reset_n;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rvalid_q <= '0;
            rdata_q  <= '0;
            wb_addr  <= '0;
            wb_data  <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                rvalid_q[i] <= grant[i] & win_rd;
                if (grant[i] && win_rd) rdata_q[i] <= rf_rData;
            end
            if ((|grant) && win_op == OP_ADD) begin
                wb_addr <= win_addr;
                wb_data <= rf_rData + win_data;
            end
        end
    end

    assign rvalid0 = rvalid_q[0];
    assign rvalid1 = rvalid_q[1];
    assign rdata0  = rdata_q[0];
    assign rdata1  = rdata_q[1];
endmodule

// File: tb/tb_rf_arbiter.sv
// Directed bench for rf_arbiter with a behavioural 8x32 register file attached.
module tb_rf_arbiter;
    import rf_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req0, req1;
    logic [1:0]  op0, op1;
    logic [2:0]  addr0, addr1;
    logic [31:0] data0, data1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic [2:0]  rf_wAddr, rf_rAddr;
    logic [31:0] rf_wData, rf_rData;
    logic        rf_we;
    logic [31:0] regs [8];
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) if (rf_we) regs[rf_wAddr] <= rf_wData;
    assign rf_rData = regs[rf_rAddr];

    rf_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .req0(req0), .op0(op0), .addr0(addr0), .data0(data0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .op1(op1), .addr1(addr1), .data1(data1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .rf_wAddr(rf_wAddr), .rf_wData(rf_wData), .rf_we(rf_we),
        .rf_rAddr(rf_rAddr), .rf_rData(rf_rData)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic set0(input logic r, input logic [1:0] op, input logic [2:0] a, input logic [31:0] d);
        req0 = r; op0 = op; addr0 = a; data0 = d;
    endtask

    task automatic set1(input logic r, input logic [1:0] op, input logic [2:0] a, input logic [31:0] d);
        req1 = r; op1 = op; addr1 = a; data1 = d;
    endtask

    task automatic post();
        @(posedge clk); #1;
    endtask

    task automatic pre();
        @(negedge clk); #1;
    endtask

    task automatic wr(input int c, input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        if (c == 0) set0(1'b1, OP_WRITE, a, d);
        else        set1(1'b1, OP_WRITE, a, d);
        post();
        req0 = 1'b0; req1 = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        set0(1'b1, OP_WRITE, 3'd5, 32'h1234);
        set1(1'b0, OP_READ, 3'd0, 32'h0);
        #3;
        chk("rst_gnt0", gnt0, 1'b0);
        chk("rst_we", rf_we, 1'b0);
        chk("rst_rvalid0", rvalid0, 1'b0);
        chk("rst_rvalid1", rvalid1, 1'b0);
        chk("rst_rdata0", rdata0, 32'h0);
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1; req0 = 1'b0;

        wr(0, 3'd1, 32'h0000_1111);
        wr(0, 3'd2, 32'h0000_2222);

        // write then read-back through the other client
        @(negedge clk); set0(1'b1, OP_WRITE, 3'd5, 32'hDEAD_BEEF); #1;
        chk("wr5_gnt0", gnt0, 1'b1);
        chk("wr5_we", rf_we, 1'b1);
        chk("wr5_waddr", rf_wAddr, 3'd5);
        chk("wr5_wdata", rf_wData, 32'hDEAD_BEEF);
        post(); req0 = 1'b0;
        chk("wr5_norvalid", rvalid0, 1'b0);
        @(negedge clk); set1(1'b1, OP_READ, 3'd5, 32'h0); #1;
        chk("rd5_gnt1", gnt1, 1'b1);
        chk("rd5_we", rf_we, 1'b0);
        post(); req1 = 1'b0;
        chk("rd5_rvalid1", rvalid1, 1'b1);
        chk("rd5_rdata1", rdata1, 32'hDEAD_BEEF);
        post();
        chk("rd5_pulse", rvalid1, 1'b0);

        // both clients continuously requesting alternate starting with client 0
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            set0(1'b1, OP_READ, 3'd1, 32'h0);
            set1(1'b1, OP_READ, 3'd2, 32'h0);
            #1;
            chk($sformatf("alt%0d_gnt0", i), gnt0, (i % 2 == 0));
            chk($sformatf("alt%0d_gnt1", i), gnt1, (i % 2 == 1));
            post();
            chk($sformatf("alt%0d_rv0", i), rvalid0, (i % 2 == 0));
            chk($sformatf("alt%0d_rv1", i), rvalid1, (i % 2 == 1));
            if (i % 2 == 0) chk($sformatf("alt%0d_rd0", i), rdata0, 32'h0000_1111);
            else            chk($sformatf("alt%0d_rd1", i), rdata1, 32'h0000_2222);
        end
        req0 = 1'b0; req1 = 1'b0;

        // add with wrap-around, then a read stalled behind the write-back
        wr(0, 3'd3, 32'hFFFF_FFFE);
        @(negedge clk); set0(1'b1, OP_ADD, 3'd3, 32'd3); #1;
        chk("add_gnt0", gnt0, 1'b1);
        chk("add_we", rf_we, 1'b0);
        chk("add_raddr", rf_rAddr, 3'd3);
        post();
        chk("add_rv0", rvalid0, 1'b1);
        chk("add_old", rdata0, 32'hFFFF_FFFE);
        @(negedge clk); set0(1'b1, OP_READ, 3'd3, 32'h0); #1;
        chk("wb_gnt0", gnt0, 1'b0);
        chk("wb_we", rf_we, 1'b1);
        chk("wb_waddr", rf_wAddr, 3'd3);
        chk("wb_wdata", rf_wData, 32'h0000_0001);
        chk("wb_raddr", rf_rAddr, 3'd3);
        post();
        chk("wb_norv", rvalid0, 1'b0);
        pre();
        chk("rd3_gnt0", gnt0, 1'b1);
        post(); req0 = 1'b0;
        chk("rd3_rv0", rvalid0, 1'b1);
        chk("rd3_data", rdata0, 32'h0000_0001);

        // nop consumes the turn: client 1 wins the next contested cycle
        wr(1, 3'd4, 32'd10);
        @(negedge clk); set0(1'b1, OP_NOP, 3'd4, 32'h0); #1;
        chk("nop_gnt0", gnt0, 1'b1);
        chk("nop_we", rf_we, 1'b0);
        post();
        chk("nop_norv", rvalid0, 1'b0);
        @(negedge clk); set0(1'b1, OP_READ, 3'd4, 32'h0); set1(1'b1, OP_READ, 3'd4, 32'h0); #1;
        chk("nop_next_gnt1", gnt1, 1'b1);
        chk("nop_next_gnt0", gnt0, 1'b0);
        post(); req1 = 1'b0;
        chk("nop_rv1", rvalid1, 1'b1);
        chk("nop_rd1", rdata1, 32'd10);
        pre();
        chk("nop_then_gnt0", gnt0, 1'b1);
        post(); req0 = 1'b0;
        chk("nop_rd0", rdata0, 32'd10);

        // add from client 1 races a read of the same register from client 0
        @(negedge clk); set0(1'b1, OP_READ, 3'd3, 32'h0); set1(1'b1, OP_ADD, 3'd3, 32'd5); #1;
        chk("haz_gnt1", gnt1, 1'b1);
        chk("haz_gnt0", gnt0, 1'b0);
        post(); req1 = 1'b0;
        chk("haz_rv1", rvalid1, 1'b1);
        chk("haz_old", rdata1, 32'h0000_0001);
        pre();
        chk("haz_wb_gnt0", gnt0, 1'b0);
        chk("haz_wb_data", rf_wData, 32'h0000_0006);
        post();
        pre();
        chk("haz_rd_gnt0", gnt0, 1'b1);
        post(); req0 = 1'b0;
        chk("haz_rv0", rvalid0, 1'b1);
        chk("haz_new", rdata0, 32'h0000_0006);

        // reset asserted during the write-back of an add discards it
        @(negedge clk); set0(1'b1, OP_ADD, 3'd4, 32'd7); #1;
        chk("rstwb_gnt0", gnt0, 1'b1);
        post(); req0 = 1'b0;
        chk("rstwb_old", rdata0, 32'd10);
        pre();
        chk("rstwb_we_pre", rf_we, 1'b1);
        reset_n = 1'b0; #1;
        chk("rstwb_we", rf_we, 1'b0);
        chk("rstwb_rv0", rvalid0, 1'b0);
        chk("rstwb_rv1", rvalid1, 1'b0);
        chk("rstwb_rd0", rdata0, 32'h0);
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk); set0(1'b1, OP_READ, 3'd4, 32'h0); set1(1'b1, OP_READ, 3'd2, 32'h0); #1;
        chk("post_rst_gnt0", gnt0, 1'b1);
        post(); req0 = 1'b0; req1 = 1'b0;
        chk("post_rst_reg4", rdata0, 32'd10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/rf_arbiter.md
Name: rf_arbiter

Overview:
- Two-client access controller for the 8 x 32-bit register file (one write port with synchronous write, one combinational read port).
- Accepts read, write and read-modify-write (add) requests from two independent requesters.
- Arbitrates round-robin between them and drives the register file ports directly.
- Sits between the register file and its users, such as a host bus bridge and a sequencer.

Parameters:
- DATA_W, 32, data width; must match the register file word width.
- ADDR_W, 3, register address width; 2**ADDR_W registers.

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- req0  input  1  client 0 request; held high until gnt0 is sampled high
- op0  input  2  client 0 opcode: 00 read, 01 write, 10 add (RMW), 11 nop
- addr0  input  ADDR_W  client 0 register address
- data0  input  DATA_W  client 0 write data or addend
- gnt0  output  1  client 0 request accepted this cycle
- rvalid0  output  1  client 0 read data valid (1-cycle pulse)
- rdata0  output  DATA_W  client 0 read data
- req1, op1, addr1, data1, gnt1, rvalid1, rdata1  as above, for client 1
- rf_wAddr  output  ADDR_W  register file write address
- rf_wData  output  DATA_W  register file write data
- rf_we  output  1  register file write enable
- rf_rAddr  output  ADDR_W  register file read address
- rf_rData  input  DATA_W  register file read data (combinational from rf_rAddr)

Behaviour:
- Reset values (reset_n low, asynchronous):
  - state = IDLE; rr_last = 1, so client 0 has first priority.
  - rvalid0/1 = 0, rdata0/1 = 0, wb_addr = 0, wb_data = 0.
  - gnt0/1 and rf_we forced 0 while reset_n is low.
- FSM states: IDLE, RMW_WB.
- IDLE, arbitration:
  - Only one client requesting: that client wins.
  - Both requesting: the client that is not rr_last wins.
  - The winner's gnt is asserted combinationally in the same cycle (acceptance cycle).
  - rr_last updates to the winner at the clock edge.
  - No request: no gnt, rf_we = 0, rf_rAddr = addr0.
- Read (00), acceptance cycle:
  - rf_rAddr = winner addr.
  - rf_rData is registered into the winner's rdata.
  - The winner's rvalid pulses high exactly one cycle later (latency 1).
- Write (01), acceptance cycle:
  - rf_we = 1, rf_wAddr = addr, rf_wData = data; the register updates at that edge.
  - No rvalid.
- Add (10), acceptance cycle:
  - rf_rAddr = addr; old value registered to rdata; rvalid pulses next cycle and returns the OLD value.
  - wb_data <= rf_rData + data, truncated to DATA_W (wraps modulo 2**DATA_W, no carry out).
  - wb_addr <= addr; state -> RMW_WB.
- RMW_WB, one cycle only:
  - rf_we = 1, rf_wAddr = wb_addr, rf_wData = wb_data.
  - No gnt to either client; state -> IDLE.
- Nop (11): granted and consumes the arbitration turn; no register file access, no rvalid.
- Hazard ordering: the RMW_WB stall guarantees that any request accepted after an add observes the written-back value.
- Back-to-back requests: one acceptance per IDLE cycle, so continuous reads or writes sustain 1 operation per clock.
- Both clients requesting continuously alternate strictly: 0, 1, 0, 1, ...
- rf_rAddr in the RMW_WB cycle = wb_addr (don't-care to the register file, fixed for determinism).
- Reset mid-RMW: the pending write-back is discarded and no write occurs; rvalid is cleared.
- A request that changes fields or drops before being granted is not a protocol violation; the arbiter only samples in the acceptance cycle.

Decomposition:
- Shared package rf_pkg:
  - opcode constants OP_READ = 2'b00, OP_WRITE = 2'b01, OP_ADD = 2'b10, OP_NOP = 2'b11.
  - FSM state encodings ST_IDLE, ST_RMW_WB.
  - defaults RF_DATA_W = 32, RF_ADDR_W = 3.
- One natural sub-module: rr_arbiter2.
  - Inputs: req[1:0], enable.
  - Outputs: one-hot grant.
  - Internal: the rr_last register.
  - Instantiated once; enable = (state == IDLE).

Test Plan:
- Reset, then client 0 writes 32'hDEADBEEF to reg 5 → gnt0 = 1 the same cycle, rf_we = 1, rf_wAddr = 5. Client 1 then reads reg 5 → rvalid1 pulses 1 cycle later with rdata1 = 32'hDEADBEEF.
- req0 and req1 both held high with reads of reg 1 and reg 2 for 6 cycles → grants alternate 0, 1, 0, 1, 0, 1, starting with client 0, with exactly one rvalid per grant.
- Reg 3 = 32'hFFFF_FFFE; client 0 adds 3 to reg 3 → rvalid0 returns 32'hFFFF_FFFE, write-back cycle shows rf_wData = 32'h0000_0001 with no gnt that cycle, and a following read of reg 3 returns 32'h0000_0001.
- Add issued by client 1 while client 0 has a pending read of the same register → client 0 is granted only after RMW_WB and sees the updated value.
- Assert reset_n low during RMW_WB of an add to reg 4 (original value 10) → rf_we drops immediately, reg 4 stays 10, and rvalid0/1 = 0 after reset.
- Client 0 issues a nop → gnt0 = 1, rf_we = 0, no rvalid0, and rr_last = 0 so a simultaneous req1 wins next.
